cau_op_sequencer: RTL and testbench

- Sequential front end that issues complex-arithmetic operations to one instance of the complex arithmetic unit (CAU) and returns the results.
- Accepts commands over a valid/ready interface and latches the operands.
- Drives CAU operand and mode inputs for one or two passes, then registers the result and holds it on a valid/ready result interface.
- Adds the fused multiply-accumulate (A*B + C) needed by the QFT phase/butterfly datapath, plus a sticky overflow flag.

---
 rtl/cau_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cau_op_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cau_op_sequencer.sv
// cau_op_sequencer: command front end for the complex arithmetic unit (CAU).
// Latches one command, runs the CAU for one pass (MUL/ADD/ABS) or two passes
// (MAC = A*B then P+C), and holds the registered result on a valid/ready port.
// All values are sign-magnitude: MSB is the sign, the rest is the magnitude.

// cau_core: combinational complex arithmetic unit.
// sum=1 -> S = A + B; abs=1 -> S = A * conj(A); otherwise S = A * B.
// Every partial product and sum is truncated to DATA_W; o_ovf flags any loss.
// A zero magnitude is always reported with a positive sign.
module cau_core #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_a_r,
   input  logic [DATA_W-1:0] i_a_i,
   input  logic [DATA_W-1:0] i_b_r,
   input  logic [DATA_W-1:0] i_b_i,
   input  logic              i_sum,
   input  logic              i_abs,
   output logic [DATA_W-1:0] o_s_r,
   output logic [DATA_W-1:0] o_s_i,
   output logic              o_ovf
);
   localparam int M = DATA_W - 1;

   // Returns {overflow, sign, magnitude}.
   function automatic logic [DATA_W:0] sm_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      logic [M:0]   s;
      logic [M-1:0] mag;
      logic         sgn;
      logic         ov;
      s   = '0;
      mag = '0;
      sgn = 1'b0;
      ov  = 1'b0;
      if (a[M] == b[M]) begin
         s   = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
         mag = s[M-1:0];
         sgn = a[M];
         ov  = s[M];
      end else if (a[M-1:0] >= b[M-1:0]) begin
         mag = a[M-1:0] - b[M-1:0];
         sgn = a[M];
      end else begin
         mag = b[M-1:0] - a[M-1:0];
         sgn = b[M];
      end
      if (mag == '0) sgn = 1'b0;
      return {ov, sgn, mag};
   endfunction

   // Returns {overflow, sign, magnitude}.
   function automatic logic [DATA_W:0] sm_mul(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      logic [2*M-1:0] p;
      logic [M-1:0]   mag;
      logic           sgn;
      logic           ov;
      p   = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
      mag = p[M-1:0];
      ov  = |p[2*M-1:M];
      sgn = a[M] ^ b[M];
      if (mag == '0) sgn = 1'b0;
      return {ov, sgn, mag};
   endfunction

   // ABS reuses the multiplier with B = conj(A): flip the sign of A's imaginary part.
   logic [DATA_W-1:0] w_b_r;
   logic [DATA_W-1:0] w_b_i;
   assign w_b_r = i_abs ? i_a_r : i_b_r;
   assign w_b_i = i_abs ? {~i_a_i[M], i_a_i[M-1:0]} : i_b_i;

   // Four partial products: ar*br, ai*bi, ar*bi, ai*br.
   logic [DATA_W-1:0] w_mx   [4];
   logic [DATA_W-1:0] w_my   [4];
   logic [DATA_W:0]   w_prod [4];
   assign w_mx[0] = i_a_r;  assign w_my[0] = w_b_r;
   assign w_mx[1] = i_a_i;  assign w_my[1] = w_b_i;
   assign w_mx[2] = i_a_r;  assign w_my[2] = w_b_i;
   assign w_mx[3] = i_a_i;  assign w_my[3] = w_b_r;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_prod
         assign w_prod[gi] = sm_mul(w_mx[gi], w_my[gi]);
      end
   endgenerate

   // Real part subtracts ai*bi by flipping its sign before the add.
   logic [DATA_W:0] w_mul_re;
   logic [DATA_W:0] w_mul_im;
   logic [DATA_W:0] w_add_re;
   logic [DATA_W:0] w_add_im;
   assign w_mul_re = sm_add(w_prod[0][M:0], {~w_prod[1][M], w_prod[1][M-1:0]});
   assign w_mul_im = sm_add(w_prod[2][M:0], w_prod[3][M:0]);
   assign w_add_re = sm_add(i_a_r, i_b_r);
   assign w_add_im = sm_add(i_a_i, i_b_i);

   // Select the sum or product path and merge the overflow flags of that path.
   always_comb begin
      o_s_r = w_mul_re[M:0];
      o_s_i = w_mul_im[M:0];
      o_ovf = w_prod[0][DATA_W] | w_prod[1][DATA_W] | w_prod[2][DATA_W] |
              w_prod[3][DATA_W] | w_mul_re[DATA_W] | w_mul_im[DATA_W];
      if (i_sum) begin
         o_s_r = w_add_re[M:0];
         o_s_i = w_add_im[M:0];
         o_ovf = w_add_re[DATA_W] | w_add_im[DATA_W];
      end
   end
endmodule

module cau_op_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a_r,
   input  logic [DATA_W-1:0] cmd_a_i,
   input  logic [DATA_W-1:0] cmd_b_r,
   input  logic [DATA_W-1:0] cmd_b_i,
   input  logic [DATA_W-1:0] cmd_c_r,
   input  logic [DATA_W-1:0] cmd_c_i,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_r,
   output logic [DATA_W-1:0] res_i,
   output logic              res_ovf,
   output logic              sticky_ovf,
   input  logic              ovf_clr,
   output logic              busy
);
   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_ABS = 2'b10;
   localparam logic [1:0] OP_MAC = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_HOLD} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_a_r, r_a_i, r_b_r, r_b_i, r_c_r, r_c_i;
   logic [DATA_W-1:0] r_p_r, r_p_i;
   logic              r_p_ovf;
   logic [DATA_W-1:0] r_res_r, r_res_i;
   logic              r_res_ovf;
   logic              r_sticky;

   logic              w_accept;
   logic              w_cap_p;
   logic              w_cap_res;
   logic              w_res_ovf_next;
   logic [DATA_W-1:0] w_cau_a_r, w_cau_a_i, w_cau_b_r, w_cau_b_i;
   logic              w_cau_sum, w_cau_abs;
   logic [DATA_W-1:0] w_cau_s_r, w_cau_s_i;
   logic              w_cau_ovf;

   cau_core #(.DATA_W(DATA_W)) u_cau (
      .i_a_r (w_cau_a_r),
      .i_a_i (w_cau_a_i),
      .i_b_r (w_cau_b_r),
      .i_b_i (w_cau_b_i),
      .i_sum (w_cau_sum),
      .i_abs (w_cau_abs),
      .o_s_r (w_cau_s_r),
      .o_s_i (w_cau_s_i),
      .o_ovf (w_cau_ovf)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state, CAU operand/mode steering and capture strobes.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_cap_p      = 1'b0;
      w_cap_res    = 1'b0;
      w_cau_a_r    = r_a_r;
      w_cau_a_i    = r_a_i;
      w_cau_b_r    = r_b_r;
      w_cau_b_i    = r_b_i;
      w_cau_sum    = 1'b0;
      w_cau_abs    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_EXEC1;
            end
         end
         S_EXEC1: begin
            w_cau_sum = (r_op == OP_ADD);
            w_cau_abs = (r_op == OP_ABS);
            if (r_op == OP_MAC) begin
               w_cap_p      = 1'b1;
               w_state_next = S_EXEC2;
            end else begin
               w_cap_res    = 1'b1;
               w_state_next = S_HOLD;
            end
         end
         S_EXEC2: begin
            w_cau_a_r    = r_p_r;
            w_cau_a_i    = r_p_i;
            w_cau_b_r    = r_c_r;
            w_cau_b_i    = r_c_i;
            w_cau_sum    = 1'b1;
            w_cap_res    = 1'b1;
            w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (res_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // A MAC result carries the overflow of both its product and its add pass.
   assign w_res_ovf_next = (r_state == S_EXEC2) ? (r_p_ovf | w_cau_ovf) : w_cau_ovf;

   // Command latch, MAC product register and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= OP_MUL;
         r_a_r     <= '0;
         r_a_i     <= '0;
         r_b_r     <= '0;
         r_b_i     <= '0;
         r_c_r     <= '0;
         r_c_i     <= '0;
         r_p_r     <= '0;
         r_p_i     <= '0;
         r_p_ovf   <= 1'b0;
         r_res_r   <= '0;
         r_res_i   <= '0;
         r_res_ovf <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= cmd_op;
            r_a_r <= cmd_a_r;
            r_a_i <= cmd_a_i;
            r_b_r <= cmd_b_r;
            r_b_i <= cmd_b_i;
            r_c_r <= cmd_c_r;
            r_c_i <= cmd_c_i;
         end
         if (w_cap_p) begin
            r_p_r   <= w_cau_s_r;
            r_p_i   <= w_cau_s_i;
            r_p_ovf <= w_cau_ovf;
         end
         if (w_cap_res) begin
            r_res_r   <= w_cau_s_r;
            r_res_i   <= w_cau_s_i;
            r_res_ovf <= w_res_ovf_next;
         end
      end
   end

   // Sticky overflow: an overflowing capture beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                             r_sticky <= 1'b0;
      else if (w_cap_res && w_res_ovf_next) r_sticky <= 1'b1;
      else if (ovf_clr)                    r_sticky <= 1'b0;
   end

   assign cmd_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign res_valid  = (r_state == S_HOLD);
   assign res_r      = r_res_r;
   assign res_i      = r_res_i;
   assign res_ovf    = r_res_ovf;
   assign sticky_ovf = r_sticky;
endmodule

// File: tb/tb_cau_op_sequencer.sv
// Self-checking bench for cau_op_sequencer: table vectors, random commands
// checked against an integer model, and hand sequences for latency,
// backpressure, sticky overflow and mid-operation reset.
module tb_cau_op_sequencer;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_a_r, cmd_a_i, cmd_b_r, cmd_b_i, cmd_c_r, cmd_c_i;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_r, res_i;
   logic          res_ovf;
   logic          sticky_ovf;
   logic          ovf_clr;
   logic          busy;

   always #5 clk = ~clk;

   cau_op_sequencer #(.DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a_r    (cmd_a_r),
      .cmd_a_i    (cmd_a_i),
      .cmd_b_r    (cmd_b_r),
      .cmd_b_i    (cmd_b_i),
      .cmd_c_r    (cmd_c_r),
      .cmd_c_i    (cmd_c_i),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_r      (res_r),
      .res_i      (res_i),
      .res_ovf    (res_ovf),
      .sticky_ovf (sticky_ovf),
      .ovf_clr    (ovf_clr),
      .busy       (busy)
   );

   typedef struct {
      logic [1:0]    op;
      logic [DW-1:0] ar, ai, br, bi, cr, ci;
      logic [DW-1:0] er, ei;
      logic          eo;
   } vec_t;

   typedef struct {
      logic [DW-1:0] r, i;
      logic          o;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------- reference model (plain signed integers) ----------------
   function automatic longint sm2i(input logic [DW-1:0] x);
      longint m;
      m = longint'(x[DW-2:0]);
      return x[DW-1] ? -m : m;
   endfunction

   // Returns {overflow, sign-magnitude value truncated to DW bits}.
   function automatic logic [DW:0] to_sm(input longint v);
      longint m, t;
      logic   ov;
      m  = (v < 0) ? -v : v;
      ov = (m >= 64'sh8000_0000);
      t  = m & 64'sh7FFF_FFFF;
      return {ov, (v < 0) && (t != 0), t[DW-2:0]};
   endfunction

   function automatic exp_t model(input logic [1:0] op,
                                  input logic [DW-1:0] ar, ai, br, bi, cr, ci);
      exp_t        e;
      longint      xr, xi, yr, yi;
      logic [DW:0] p1, p2, p3, p4, re, im, sr, si;
      xr = sm2i(ar); xi = sm2i(ai);
      yr = sm2i(br); yi = sm2i(bi);
      if (op == 2'b01) begin
         re  = to_sm(xr + yr);
         im  = to_sm(xi + yi);
         e.r = re[DW-1:0]; e.i = im[DW-1:0]; e.o = re[DW] | im[DW];
         return e;
      end
      if (op == 2'b10) begin
         yr = xr;
         yi = -xi;
      end
      p1 = to_sm(xr * yr);
      p2 = to_sm(xi * yi);
      p3 = to_sm(xr * yi);
      p4 = to_sm(xi * yr);
      re = to_sm(sm2i(p1[DW-1:0]) - sm2i(p2[DW-1:0]));
      im = to_sm(sm2i(p3[DW-1:0]) + sm2i(p4[DW-1:0]));
      e.r = re[DW-1:0]; e.i = im[DW-1:0];
      e.o = p1[DW] | p2[DW] | p3[DW] | p4[DW] | re[DW] | im[DW];
      if (op == 2'b11) begin
         sr  = to_sm(sm2i(e.r) + sm2i(cr));
         si  = to_sm(sm2i(e.i) + sm2i(ci));
         e.r = sr[DW-1:0]; e.i = si[DW-1:0];
         e.o = e.o | sr[DW] | si[DW];
      end
      return e;
   endfunction

   // ---------------- cycle stepping with result monitor ----------------
   // Called at posedge+1: samples outputs, pops the scoreboard on a handshake
   // that the coming edge will complete, then advances one clock.
   task automatic tick();
      exp_t e;
      if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got res=(0x%0h,0x%0h), expected no result", res_r, res_i);
         end else begin
            e = sb_q.pop_front();
            check("res_r", res_r, e.r);
            check("res_i", res_i, e.i);
            check("res_ovf", res_ovf, e.o);
            $display("result  res=(0x%08h,0x%08h) ovf=%0d", res_r, res_i, res_ovf);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [DW-1:0] ar, ai, br, bi, cr, ci,
                       input bit do_push, input exp_t e, output int waits);
      bit acc;
      acc       = 1'b0;
      waits     = 0;
      cmd_op    = op;
      cmd_a_r   = ar; cmd_a_i = ai;
      cmd_b_r   = br; cmd_b_i = bi;
      cmd_c_r   = cr; cmd_c_i = ci;
      cmd_valid = 1'b1;
      for (int n = 0; n < 20 && !acc; n++) begin
         if (cmd_ready) acc = 1'b1;
         else           waits++;
         tick();
      end
      cmd_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got cmd_ready=0 for 20 cycles, expected accept");
      end else begin
         if (do_push) sb_q.push_back(e);
         $display("cmd     op=%0d a=(0x%08h,0x%08h) b=(0x%08h,0x%08h) c=(0x%08h,0x%08h)",
                  op, ar, ai, br, bi, cr, ci);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 50; n++) begin
         if (!busy) return;
         tick();
      end
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 for 50 cycles, expected 0");
   endtask

   function automatic logic [DW-1:0] rnd_val();
      logic [DW-1:0] v;
      v = $urandom;
      if ($urandom_range(0, 5) != 0) v = {v[DW-1], 15'd0, v[15:0]};
      return v;
   endfunction

   vec_t vecs[9];
   exp_t e, e2;
   int   w;
   logic [1:0]    rop;
   logic [DW-1:0] rar, rai, rbr, rbi, rcr, rci;

   initial begin
      //          op     ar            ai            br            bi            cr            ci            er            ei            eo
      vecs[0] = '{2'b01, 32'd5,        32'h80000003, 32'd2,        32'd7,        32'd0,        32'd0,        32'd7,        32'd4,        1'b0};
      vecs[1] = '{2'b11, 32'd9,        32'd9,        32'd0,        32'd0,        32'h80000004, 32'd6,        32'h80000004, 32'd6,        1'b0};
      vecs[2] = '{2'b00, 32'd3,        32'd2,        32'd4,        32'h80000005, 32'd0,        32'd0,        32'd22,       32'h80000007, 1'b0};
      vecs[3] = '{2'b10, 32'd3,        32'h80000004, 32'h12345678, 32'h9ABCDEF0, 32'd0,        32'd0,        32'd25,       32'd0,        1'b0};
      vecs[4] = '{2'b01, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 32'd0,        32'd0,        32'd0,        32'h7FFFFFFE, 32'd0,        1'b1};
      vecs[5] = '{2'b00, 32'h00010000, 32'd0,        32'h00010000, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b1};
      vecs[6] = '{2'b11, 32'd2,        32'd3,        32'd4,        32'd5,        32'd1,        32'h80000001, 32'h80000006, 32'd21,       1'b0};
      vecs[7] = '{2'b01, 32'd5,        32'd0,        32'h80000005, 32'd0,        32'd0,        32'd0,        32'd0,        32'd0,        1'b0};
      vecs[8] = '{2'b11, 32'h40000000, 32'd0,        32'd1,        32'd0,        32'h40000000, 32'd0,        32'd0,        32'd0,        1'b1};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
      cmd_a_r = '0; cmd_a_i = '0; cmd_b_r = '0; cmd_b_i = '0; cmd_c_r = '0; cmd_c_i = '0;
      res_ready = 1'b0; ovf_clr = 1'b0;

      // Reset state.
      tick();
      tick();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_r", res_r, 32'd0);
      check("rst_res_i", res_i, 32'd0);
      check("rst_res_ovf", res_ovf, 1'b0);
      check("rst_sticky", sticky_ovf, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      // ADD latency and ready/busy during the operation.
      res_ready = 1'b1;
      e = '{32'd7, 32'd4, 1'b0};
      send(2'b01, 32'd5, 32'h80000003, 32'd2, 32'd7, 32'd0, 32'd0, 1'b1, e, w);
      check("add_c1_res_valid", res_valid, 1'b0);
      check("add_c1_cmd_ready", cmd_ready, 1'b0);
      check("add_c1_busy", busy, 1'b1);
      tick();
      check("add_c2_res_valid", res_valid, 1'b1);
      check("add_c2_cmd_ready", cmd_ready, 1'b0);
      tick();
      check("add_after_idle", cmd_ready, 1'b1);

      // MAC latency: result appears one cycle later than single-pass ops.
      e = '{32'h80000004, 32'd6, 1'b0};
      send(2'b11, 32'd9, 32'd9, 32'd0, 32'd0, 32'h80000004, 32'd6, 1'b1, e, w);
      check("mac_c1_res_valid", res_valid, 1'b0);
      tick();
      check("mac_c2_res_valid", res_valid, 1'b0);
      check("mac_c2_busy", busy, 1'b1);
      tick();
      check("mac_c3_res_valid", res_valid, 1'b1);
      wait_idle();

      // Table vectors issued back to back, result port always ready.
      for (int k = 0; k < 9; k++) begin
         e = '{vecs[k].er, vecs[k].ei, vecs[k].eo};
         send(vecs[k].op, vecs[k].ar, vecs[k].ai, vecs[k].br, vecs[k].bi,
              vecs[k].cr, vecs[k].ci, 1'b1, e, w);
      end
      wait_idle();

      // Backpressure: result held, second command stalled until after res_ready.
      res_ready = 1'b0;
      e = '{32'd0, 32'd0, 1'b0};
      send(2'b00, 32'd0, 32'd0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1, e, w);
      tick();
      cmd_op = 2'b00; cmd_a_r = 32'd3; cmd_a_i = 32'd2; cmd_b_r = 32'd4; cmd_b_i = 32'h80000005;
      cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp_res_valid", res_valid, 1'b1);
         check("bp_res_r", res_r, 32'd0);
         check("bp_res_i", res_i, 32'd0);
         check("bp_cmd_ready", cmd_ready, 1'b0);
         tick();
      end
      res_ready = 1'b1;
      check("bp_release_cmd_ready", cmd_ready, 1'b0);
      tick();
      e2 = '{32'd22, 32'h80000007, 1'b0};
      send(2'b00, 32'd3, 32'd2, 32'd4, 32'h80000005, 32'd0, 32'd0, 1'b1, e2, w);
      check("bp_second_accept_wait", w, 0);
      wait_idle();

      // Sticky overflow: set, hold across a clean result, clear, set-beats-clear.
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_clr0", sticky_ovf, 1'b0);
      e = '{32'h7FFFFFFE, 32'd0, 1'b1};
      send(2'b01, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 1'b1, e, w);
      wait_idle();
      check("sticky_set", sticky_ovf, 1'b1);
      e = '{32'd3, 32'd0, 1'b0};
      send(2'b01, 32'd1, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 1'b1, e, w);
      wait_idle();
      check("sticky_hold", sticky_ovf, 1'b1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_clr", sticky_ovf, 1'b0);
      e = '{32'h7FFFFFFE, 32'd0, 1'b1};
      send(2'b01, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0, 1'b1, e, w);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_set_wins", sticky_ovf, 1'b1);
      check("sticky_res_ovf", res_ovf, 1'b1);
      wait_idle();

      // Reset during EXEC2 of a MAC: nothing is ever presented.
      send(2'b11, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd1, 1'b0, e, w);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_res_valid", res_valid, 1'b0);
      check("mid_rst_res_r", res_r, 32'd0);
      check("mid_rst_res_i", res_i, 32'd0);
      check("mid_rst_cmd_ready", cmd_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_sticky", sticky_ovf, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("mid_rst_no_result", res_valid, 1'b0);
         tick();
      end

      // Random commands against the model with random result backpressure.
      for (int k = 0; k < 40; k++) begin
         rop = 2'($urandom_range(0, 3));
         rar = rnd_val(); rai = rnd_val(); rbr = rnd_val();
         rbi = rnd_val(); rcr = rnd_val(); rci = rnd_val();
         e = model(rop, rar, rai, rbr, rbi, rcr, rci);
         res_ready = 1'($urandom_range(0, 1));
         send(rop, rar, rai, rbr, rbi, rcr, rci, 1'b1, e, w);
         for (int d = 0; d < int'($urandom_range(0, 4)); d++) tick();
         res_ready = 1'b1;
         wait_idle();
      end
      tick();

      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
